// File: rtl/read_return_checker.sv
// Read-return checker for the DDR2 controller's non-backpressured read port.
// Matches words to posted read descriptors, tracks bursts and buffers words onto a ready/valid stream.
module read_return_checker #(
  parameter int unsigned ADDR_W     = 25,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned DESC_DEPTH = 8,
  parameter int unsigned OUT_DEPTH  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_valid,
  input  logic [ADDR_W-1:0]             req_addr,
  input  logic [1:0]                    req_sz,
  output logic                          req_ready,
  input  logic                          validout,
  input  logic [DATA_W-1:0]             dout,
  input  logic [ADDR_W-1:0]             raddr,
  output logic                          out_valid,
  output logic [DATA_W-1:0]             out_data,
  output logic [ADDR_W-1:0]             out_addr,
  output logic                          out_last,
  input  logic                          out_ready,
  output logic                          burst_done,
  output logic                          err_addr,
  output logic                          err_unexpected,
  output logic                          err_overflow,
  output logic [15:0]                   words_rcvd,
  output logic [$clog2(DESC_DEPTH):0]   desc_pending
);

  localparam int unsigned DPW = $clog2(DESC_DEPTH);
  localparam int unsigned OPW = $clog2(OUT_DEPTH);
  localparam int unsigned WW  = DATA_W + ADDR_W + 1;

  localparam logic [DPW:0]   DescFull = (DPW+1)'(DESC_DEPTH);
  localparam logic [DPW:0]   DescOne  = (DPW+1)'(1);
  localparam logic [DPW-1:0] DPtrOne  = DPW'(1);
  localparam logic [OPW:0]   OutFull  = (OPW+1)'(OUT_DEPTH);
  localparam logic [OPW:0]   OutOne   = (OPW+1)'(1);
  localparam logic [OPW-1:0] OPtrOne  = OPW'(1);
  localparam logic [ADDR_W-1:0] AddrOne = ADDR_W'(1);

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  // Descriptor FIFO
  logic [ADDR_W-1:0] desc_addr_mem [DESC_DEPTH];
  logic [1:0]        desc_sz_mem   [DESC_DEPTH];
  logic [DPW-1:0]    desc_wr_q, desc_wr_d, desc_rd_q, desc_rd_d;
  logic [DPW:0]      desc_cnt_q, desc_cnt_d;
  logic              desc_push, desc_pop;
  logic [ADDR_W-1:0] desc_head_addr;
  logic [1:0]        desc_head_sz;

  // Output word FIFO
  logic [WW-1:0]     out_mem [OUT_DEPTH];
  logic [OPW-1:0]    out_wr_q, out_wr_d, out_rd_q, out_rd_d;
  logic [OPW:0]      out_cnt_q, out_cnt_d;
  logic              out_push, out_pop, out_full;

  // Burst tracking
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [5:0]        beat_q, beat_d;
  logic [5:0]        len_q, len_d;
  logic              word_accept, word_last, unexpected, overflow;
  logic [ADDR_W-1:0] exp_addr;

  logic              burst_done_q, burst_done_d;
  logic              err_addr_q, err_addr_d;
  logic              err_unexp_q, err_unexp_d;
  logic              err_ovf_q, err_ovf_d;
  logic [15:0]       words_q, words_d;

  assign req_ready      = (desc_cnt_q != DescFull);
  assign desc_push      = req_valid & req_ready;
  assign desc_head_addr = desc_addr_mem[desc_rd_q];
  assign desc_head_sz   = desc_sz_mem[desc_rd_q];

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    beat_d      = beat_q;
    len_d       = len_q;
    desc_pop    = 1'b0;
    word_accept = 1'b0;
    word_last   = 1'b0;
    unexpected  = 1'b0;
    exp_addr    = cur_addr_q;
    case (state_q)
      StIdle: begin
        if (validout) begin
          if (desc_cnt_q != '0) begin
            desc_pop    = 1'b1;
            word_accept = 1'b1;
            exp_addr    = desc_head_addr;
            len_d       = {1'b0, desc_head_sz, 3'b000} + 6'd8;
            beat_d      = 6'd1;
            cur_addr_d  = desc_head_addr + AddrOne;
            state_d     = StActive;
          end else begin
            unexpected = 1'b1;
          end
        end
      end
      StActive: begin
        if (validout) begin
          word_accept = 1'b1;
          beat_d      = beat_q + 6'd1;
          cur_addr_d  = cur_addr_q + AddrOne;
          if (beat_q == len_q - 6'd1) begin
            word_last = 1'b1;
            state_d   = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A pop in the same cycle frees a slot, so a push at full is still taken.
  assign out_full  = (out_cnt_q == OutFull);
  assign out_pop   = out_valid & out_ready;
  assign out_push  = word_accept & (~out_full | out_pop);
  assign overflow  = word_accept & out_full & ~out_pop;

  always_comb begin
    desc_wr_d  = desc_push ? desc_wr_q + DPtrOne : desc_wr_q;
    desc_rd_d  = desc_pop  ? desc_rd_q + DPtrOne : desc_rd_q;
    desc_cnt_d = desc_cnt_q;
    if (desc_push && !desc_pop) begin
      desc_cnt_d = desc_cnt_q + DescOne;
    end else if (desc_pop && !desc_push) begin
      desc_cnt_d = desc_cnt_q - DescOne;
    end
    out_wr_d  = out_push ? out_wr_q + OPtrOne : out_wr_q;
    out_rd_d  = out_pop  ? out_rd_q + OPtrOne : out_rd_q;
    out_cnt_d = out_cnt_q;
    if (out_push && !out_pop) begin
      out_cnt_d = out_cnt_q + OutOne;
    end else if (out_pop && !out_push) begin
      out_cnt_d = out_cnt_q - OutOne;
    end
    burst_done_d = word_accept & word_last;
    err_addr_d   = err_addr_q | (word_accept & (raddr != exp_addr));
    err_unexp_d  = err_unexp_q | unexpected;
    err_ovf_d    = err_ovf_q | overflow;
    words_d      = word_accept ? words_q + 16'd1 : words_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      cur_addr_q   <= '0;
      beat_q       <= '0;
      len_q        <= '0;
      desc_wr_q    <= '0;
      desc_rd_q    <= '0;
      desc_cnt_q   <= '0;
      out_wr_q     <= '0;
      out_rd_q     <= '0;
      out_cnt_q    <= '0;
      burst_done_q <= 1'b0;
      err_addr_q   <= 1'b0;
      err_unexp_q  <= 1'b0;
      err_ovf_q    <= 1'b0;
      words_q      <= '0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      beat_q       <= beat_d;
      len_q        <= len_d;
      desc_wr_q    <= desc_wr_d;
      desc_rd_q    <= desc_rd_d;
      desc_cnt_q   <= desc_cnt_d;
      out_wr_q     <= out_wr_d;
      out_rd_q     <= out_rd_d;
      out_cnt_q    <= out_cnt_d;
      burst_done_q <= burst_done_d;
      err_addr_q   <= err_addr_d;
      err_unexp_q  <= err_unexp_d;
      err_ovf_q    <= err_ovf_d;
      words_q      <= words_d;
    end
  end

  // Storage arrays need no reset; occupancy counters gate their visibility.
  always_ff @(posedge clk) begin
    if (desc_push) begin
      desc_addr_mem[desc_wr_q] <= req_addr;
      desc_sz_mem[desc_wr_q]   <= req_sz;
    end
    if (out_push) begin
      out_mem[out_wr_q] <= {dout, raddr, word_last};
    end
  end

  assign out_valid                    = (out_cnt_q != '0);
  assign {out_data, out_addr, out_last} = out_mem[out_rd_q];
  assign burst_done                   = burst_done_q;
  assign err_addr                     = err_addr_q;
  assign err_unexpected               = err_unexp_q;
  assign err_overflow                 = err_ovf_q;
  assign words_rcvd                   = words_q;
  assign desc_pending                 = desc_cnt_q;

endmodule

// File: tb/tb_read_return_checker.sv
// Bench for read_return_checker: queue-based reference model checked every cycle,
// directed burst scenarios with literal expectations, and a randomized phase.
module tb_read_return_checker;

  typedef struct packed {logic [24:0] addr; logic [1:0] sz;} desc_t;
  typedef struct packed {logic [15:0] data; logic [24:0] addr; logic last;} word_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, validout, out_valid, out_last, out_ready;
  logic [24:0] req_addr, raddr, out_addr;
  logic [1:0]  req_sz;
  logic [15:0] dout, out_data, words_rcvd;
  logic        burst_done, err_addr, err_unexpected, err_overflow;
  logic [3:0]  desc_pending;

  int n_vec = 0;
  int n_err = 0;

  read_return_checker dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr), .req_sz(req_sz),
    .req_ready(req_ready), .validout(validout), .dout(dout), .raddr(raddr),
    .out_valid(out_valid), .out_data(out_data), .out_addr(out_addr), .out_last(out_last),
    .out_ready(out_ready), .burst_done(burst_done), .err_addr(err_addr),
    .err_unexpected(err_unexpected), .err_overflow(err_overflow), .words_rcvd(words_rcvd),
    .desc_pending(desc_pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: descriptors and words as queues, a burst as "words left to go".
  desc_t       m_desc[$];
  word_t       m_out[$];
  bit          m_active;
  logic [24:0] m_exp;
  int          m_left;
  bit          m_bd, m_ea, m_eu, m_eo;
  logic [15:0] m_words;
  word_t       got[$];

  always @(posedge clk or negedge reset) begin
    bit    pop_out, acc, last, push_d;
    int    pre_sz;
    desc_t d;
    if (!reset) begin
      m_desc.delete(); m_out.delete();
      m_active = 0; m_left = 0; m_exp = '0;
      m_bd = 0; m_ea = 0; m_eu = 0; m_eo = 0; m_words = '0;
    end else begin
      if (out_valid && out_ready) got.push_back({out_data, out_addr, out_last});
      pop_out = (m_out.size() > 0) && out_ready;
      push_d  = req_valid && (m_desc.size() < 8);
      pre_sz  = m_out.size();
      acc = 0; last = 0;
      if (validout) begin
        if (m_active) acc = 1;
        else if (m_desc.size() > 0) begin
          d = m_desc.pop_front();
          m_exp = d.addr; m_left = 8 * (int'(d.sz) + 1); m_active = 1; acc = 1;
        end else m_eu = 1;
      end
      if (push_d) m_desc.push_back({req_addr, req_sz});
      if (pop_out) void'(m_out.pop_front());
      m_bd = 0;
      if (acc) begin
        if (raddr != m_exp) m_ea = 1;
        m_words++;
        m_left--;
        last = (m_left == 0);
        if (pre_sz < 16 || pop_out) m_out.push_back({dout, raddr, last});
        else m_eo = 1;
        m_exp = m_exp + 25'd1;
        if (last) m_active = 0;
        m_bd = last;
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      chk("req_ready", req_ready, m_desc.size() < 8);
      chk("desc_pending", desc_pending, m_desc.size());
      chk("out_valid", out_valid, m_out.size() > 0);
      if (m_out.size() > 0) begin
        chk("out_data", out_data, m_out[0].data);
        chk("out_addr", out_addr, m_out[0].addr);
        chk("out_last", out_last, m_out[0].last);
      end
      chk("burst_done", burst_done, m_bd);
      chk("err_addr", err_addr, m_ea);
      chk("err_unexpected", err_unexpected, m_eu);
      chk("err_overflow", err_overflow, m_eo);
      chk("words_rcvd", words_rcvd, m_words);
    end
  end

  task automatic post(input logic [24:0] a, input logic [1:0] sz);
    @(negedge clk); req_valid = 1'b1; req_addr = a; req_sz = sz;
    @(negedge clk); req_valid = 1'b0;
  endtask

  task automatic beat(input logic [24:0] a);
    @(negedge clk); validout = 1'b1; raddr = a; dout = 16'($urandom);
  endtask

  task automatic quiet(input int n);
    repeat (n) begin
      @(negedge clk); validout = 1'b0; req_valid = 1'b0;
    end
  endtask

  initial begin
    bit has;
    logic [24:0] e;
    reset = 1'b0; req_valid = 0; req_addr = '0; req_sz = '0; validout = 0;
    dout = '0; raddr = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_desc_pending", desc_pending, 0);
    chk("rst_words", words_rcvd, 0);
    chk("rst_flags", {err_addr, err_unexpected, err_overflow, burst_done}, 0);

    // Single 8-beat burst
    got.delete();
    post(25'h100, 2'd0);
    for (int i = 0; i < 8; i++) beat(25'h100 + 25'(i));
    quiet(1);
    chk("t1_burst_done", burst_done, 1);
    quiet(3);
    chk("t1_count", got.size(), 8);
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      chk("t1_addr", got[i].addr, 25'h100 + 25'(i));
      chk("t1_last", got[i].last, i == 7);
    end
    chk("t1_words", words_rcvd, 8);
    chk("t1_flags", {err_addr, err_unexpected, err_overflow}, 0);

    // 32-beat burst across the address wrap
    got.delete();
    post(25'h1FFFFF0, 2'd3);
    chk("t2_dp_before", desc_pending, 1);
    for (int i = 0; i < 32; i++) begin
      beat(25'h1FFFFF0 + 25'(i));
      if (i == 1) chk("t2_dp_after_b1", desc_pending, 0);
    end
    quiet(4);
    chk("t2_err_addr", err_addr, 0);
    chk("t2_count", got.size(), 32);
    if (got.size() == 32) begin
      chk("t2_last_addr", got[31].addr, 25'h000000F);
      chk("t2_last", got[31].last, 1);
      chk("t2_not_last", got[30].last, 0);
    end

    // Address mismatch on beat 5
    got.delete();
    post(25'h200, 2'd1);
    for (int i = 0; i < 16; i++) beat((i == 5) ? 25'h2FF : 25'h200 + 25'(i));
    quiet(1);
    chk("t3_burst_done", burst_done, 1);
    quiet(3);
    chk("t3_err_addr", err_addr, 1);
    chk("t3_count", got.size(), 16);
    if (got.size() == 16) chk("t3_fwd_addr", got[5].addr, 25'h2FF);

    // Word with no descriptor pending
    beat(25'h123);
    quiet(1);
    chk("t4_err_unexp", err_unexpected, 1);
    chk("t4_out_valid", out_valid, 0);
    chk("t4_words", words_rcvd, 56);

    // Overflow with consumer stalled
    out_ready = 1'b0;
    post(25'h400, 2'd3);
    for (int i = 0; i < 32; i++) beat(25'h400 + 25'(i));
    quiet(1);
    chk("t5_burst_done", burst_done, 1);
    chk("t5_err_ovf", err_overflow, 1);
    chk("t5_words", words_rcvd, 88);
    got.delete();
    out_ready = 1'b1;
    quiet(20);
    chk("t5_buffered", got.size(), 16);
    if (got.size() == 16) chk("t5_tail_addr", got[15].addr, 25'h40F);
    post(25'h500, 2'd0);
    for (int i = 0; i < 8; i++) beat(25'h500 + 25'(i));
    quiet(4);
    chk("t5_words2", words_rcvd, 96);

    // Randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      req_valid = ($urandom_range(3) == 0) && (m_desc.size() < 8);
      req_addr  = 25'($urandom);
      req_sz    = 2'($urandom);
      out_ready = ($urandom_range(9) < 7);
      has = m_active || (m_desc.size() > 0);
      e = m_active ? m_exp : (m_desc.size() > 0 ? m_desc[0].addr : 25'h0);
      validout = has ? ($urandom_range(9) < 6) : ($urandom_range(19) == 0);
      raddr = ($urandom_range(15) == 0) ? 25'($urandom) : e;
      dout  = 16'($urandom);
    end
    quiet(1);

    // Descriptor FIFO full, then asynchronous reset mid-burst
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); req_valid = 1'b1; req_addr = 25'h600 + 25'(i * 32); req_sz = 2'd0;
    end
    @(negedge clk);
    chk("t6_req_ready", req_ready, 0);
    chk("t6_dp_full", desc_pending, 8);
    req_addr = 25'h999;
    @(negedge clk); req_valid = 1'b0;
    chk("t6_dp_ignored", desc_pending, 8);
    beat(25'h601);
    beat(25'h601);
    beat(25'h602);
    quiet(1);
    chk("t6_err_addr", err_addr, 1);
    chk("t6_out_valid", out_valid, 1);
    chk("t6_dp", desc_pending, 7);
    #2 reset = 1'b0;
    #1;
    chk("t6_rst_out_valid", out_valid, 0);
    chk("t6_rst_dp", desc_pending, 0);
    chk("t6_rst_flags", {err_addr, err_unexpected, err_overflow, burst_done}, 0);
    chk("t6_rst_words", words_rcvd, 0);
    @(negedge clk); reset = 1'b1;
    quiet(3);
    chk("t6_req_ready_after", req_ready, 1);
    chk("t6_bd_after", burst_done, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
